pe_link_packer: RTL and testbench

PE_LINK_PACKER -- requirements
Module: pe_link_packer

---
 rtl/pe_link_packer.sv | 130 +++++++++++++
 tb/tb_pe_link_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pe_link_packer.sv
// Packs 32-bit stream words into 3-lane mesh link flits, queues closed flits in a
// 2-entry FIFO and emits one flit per ap_start edge. States: EMPTY 0 staged | FILL 1-2 staged | WAIT closed.
module pe_link_packer #(
    parameter int LINK_WIDTH   = 130,
    parameter int WORD_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [LINK_WIDTH-1:0] out_flit,
    output logic [15:0]           flit_count
);

    localparam int PAYLOAD_W = 3 * WORD_WIDTH;
    localparam int IDLE_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {EMPTY, FILL, WAIT} state_t;

    state_t                state;
    state_t                state_next;
    logic [PAYLOAD_W-1:0]  stage_data;
    logic [1:0]            stage_cnt;
    logic                  stage_last;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [LINK_WIDTH-1:0] stage_flit;
    logic [LINK_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic [15:0]           flit_cnt;

    assign pop        = ap_start && (fifo_cnt != 2'd0);
    assign flit_count = flit_cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        case (state)
            EMPTY: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid) state_next = s_last ? WAIT : FILL;
            end
            FILL: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid) begin
                    if (s_last || stage_cnt == 2'd2) state_next = WAIT;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // occupancy is sampled before any same-edge pop, so a full FIFO never takes a push
                push = (fifo_cnt < 2'd2);
                if (push) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || push) begin
            stage_data <= '0;
            stage_cnt  <= 2'd0;
            stage_last <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < 3; k++) begin
                if (stage_cnt == 2'(k)) stage_data[k*WORD_WIDTH +: WORD_WIDTH] <= s_data;
            end
            stage_cnt  <= stage_cnt + 2'd1;
            stage_last <= s_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                                    idle_cnt <= '0;
        else if (state == FILL && !accept && state_next == FILL)      idle_cnt <= idle_cnt + 1'b1;
        else                                                          idle_cnt <= '0;
    end

    always_comb begin
        stage_flit                              = '0;
        stage_flit[LINK_WIDTH-1]                = 1'b1;
        stage_flit[PAYLOAD_W+2]                 = stage_last;
        stage_flit[PAYLOAD_W+1:PAYLOAD_W]       = stage_cnt;
        stage_flit[PAYLOAD_W-1:0]               = stage_data;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= stage_flit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            out_flit <= '0;
            flit_cnt <= 16'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (ap_start) out_flit <= pop ? fifo_mem[rd_ptr] : '0;
            if (pop)      flit_cnt <= flit_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pe_link_packer.sv
// Directed bench for pe_link_packer: inputs driven and outputs sampled on the falling edge.
module tb_pe_link_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         ap_start;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [129:0] out_flit;
    logic [15:0]  flit_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_link_packer dut (
        .clk        (clk),
        .reset      (reset),
        .ap_start   (ap_start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .out_flit   (out_flit),
        .flit_count (flit_count)
    );

    function automatic logic [129:0] mk_flit(input logic last, input logic [1:0] cnt,
                                             input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2);
        mk_flit = {1'b1, 30'b0, last, cnt, w2, w1, w0};
    endfunction

    // Holds the word until the DUT is ready, returns on the falling edge after the accept edge.
    task automatic send_word(input logic [31:0] d, input logic l);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_word_timeout data=%h s_ready=%b required 1", d, s_ready);
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ap_start = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_flit !== '0) begin n_err++; $display("FAIL reset_out_flit got %h want 0", out_flit); end
        n_vec++; if (flit_count !== 16'd0) begin n_err++; $display("FAIL reset_flit_count got %0d want 0", flit_count); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        n_vec++; if (out_flit !== '0) begin n_err++; $display("FAIL reset_idle_out got %h want 0", out_flit); end
    endtask

    task automatic test_three_words();
        logic [129:0] exp;
        exp = mk_flit(1'b1, 2'd3, 32'hA, 32'hB, 32'hC);
        send_word(32'hA, 1'b0);
        send_word(32'hB, 1'b0);
        send_word(32'hC, 1'b1);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL three_wait_s_ready got %b want 0", s_ready); end
        @(negedge clk);
        n_vec++; if (out_flit !== '0) begin n_err++; $display("FAIL three_early got %h want 0", out_flit); end
        @(negedge clk);
        n_vec++; if (out_flit !== exp) begin n_err++; $display("FAIL three_flit got %h want %h", out_flit, exp); end
        n_vec++; if (flit_count !== 16'd1) begin n_err++; $display("FAIL three_count got %0d want 1", flit_count); end
        @(negedge clk);
        n_vec++; if (out_flit !== '0) begin n_err++; $display("FAIL three_after got %h want 0", out_flit); end
    endtask

    task automatic test_flush();
        logic [129:0] exp;
        exp = mk_flit(1'b0, 2'd1, 32'h5, 32'h0, 32'h0);
        send_word(32'h5, 1'b0);
        repeat (15) @(negedge clk);
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL flush_early s_ready got %b want 1", s_ready); end
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL flush_close s_ready got %b want 0", s_ready); end
        repeat (2) @(negedge clk);
        n_vec++; if (out_flit !== exp) begin n_err++; $display("FAIL flush_flit got %h want %h", out_flit, exp); end
        n_vec++; if (flit_count !== 16'd2) begin n_err++; $display("FAIL flush_count got %0d want 2", flit_count); end
    endtask

    task automatic test_back_to_back();
        logic [129:0] held;
        logic [129:0] exp [3];
        held   = mk_flit(1'b0, 2'd1, 32'h5, 32'h0, 32'h0);
        exp[0] = mk_flit(1'b0, 2'd3, 32'd1, 32'd2, 32'd3);
        exp[1] = mk_flit(1'b0, 2'd3, 32'd4, 32'd5, 32'd6);
        exp[2] = mk_flit(1'b0, 2'd3, 32'd7, 32'd8, 32'd9);
        ap_start = 1'b0;
        for (int i = 1; i <= 9; i++) send_word(32'(i), 1'b0);
        repeat (3) @(negedge clk);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full s_ready got %b want 0", s_ready); end
        n_vec++; if (out_flit !== held) begin n_err++; $display("FAIL b2b_hold got %h want %h", out_flit, held); end
        n_vec++; if (flit_count !== 16'd2) begin n_err++; $display("FAIL b2b_hold_count got %0d want 2", flit_count); end
        ap_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (out_flit !== exp[i]) begin n_err++; $display("FAIL b2b_flit%0d got %h want %h", i, out_flit, exp[i]); end
            n_vec++; if (flit_count !== 16'(3 + i)) begin n_err++; $display("FAIL b2b_count%0d got %0d want %0d", i, flit_count, 3 + i); end
        end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_drained s_ready got %b want 1", s_ready); end
        @(negedge clk);
        n_vec++; if (out_flit !== '0) begin n_err++; $display("FAIL b2b_zero got %h want 0", out_flit); end
    endtask

    task automatic test_toggle();
        logic [129:0] exp [5];
        logic [15:0]  cnt [5];
        logic         en  [5];
        exp[0] = mk_flit(1'b1, 2'd1, 32'h11, 32'h0, 32'h0);  cnt[0] = 16'd6; en[0] = 1'b1;
        exp[1] = exp[0];                                     cnt[1] = 16'd6; en[1] = 1'b0;
        exp[2] = mk_flit(1'b1, 2'd2, 32'h22, 32'h33, 32'h0); cnt[2] = 16'd7; en[2] = 1'b1;
        exp[3] = exp[2];                                     cnt[3] = 16'd7; en[3] = 1'b0;
        exp[4] = '0;                                         cnt[4] = 16'd7; en[4] = 1'b1;
        ap_start = 1'b0;
        send_word(32'h11, 1'b1);
        send_word(32'h22, 1'b0);
        send_word(32'h33, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++; if (out_flit !== '0) begin n_err++; $display("FAIL toggle_idle got %h want 0", out_flit); end
        for (int i = 0; i < 5; i++) begin
            ap_start = en[i];
            @(negedge clk);
            n_vec++; if (out_flit !== exp[i]) begin n_err++; $display("FAIL toggle_flit%0d got %h want %h", i, out_flit, exp[i]); end
            n_vec++; if (flit_count !== cnt[i]) begin n_err++; $display("FAIL toggle_count%0d got %0d want %0d", i, flit_count, cnt[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        ap_start = 1'b0;
        send_word(32'h71, 1'b1);
        send_word(32'h72, 1'b1);
        send_word(32'h73, 1'b0);
        reset = 1'b1; ap_start = 1'b1;
        @(negedge clk);
        n_vec++; if (out_flit !== '0) begin n_err++; $display("FAIL midrst_out got %h want 0", out_flit); end
        n_vec++; if (flit_count !== 16'd0) begin n_err++; $display("FAIL midrst_count got %0d want 0", flit_count); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL midrst_s_ready got %b want 1", s_ready); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_flit !== '0 || flit_count !== 16'd0) begin
                n_err++; $display("FAIL midrst_stale%0d got %h count %0d want 0 count 0", i, out_flit, flit_count);
            end
        end
    endtask

    task automatic test_wrap();
        ap_start = 1'b0;
        @(negedge clk);
        dut.flit_cnt = 16'hFFFE;
        ap_start = 1'b1;
        send_word(32'h1, 1'b1);
        send_word(32'h2, 1'b1);
        n_vec++; if (flit_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got %h want ffff", flit_count); end
        send_word(32'h3, 1'b1);
        n_vec++; if (flit_count !== 16'h0000) begin n_err++; $display("FAIL wrap_0000 got %h want 0000", flit_count); end
        repeat (2) @(negedge clk);
        n_vec++; if (flit_count !== 16'h0001) begin n_err++; $display("FAIL wrap_0001 got %h want 0001", flit_count); end
        n_vec++;
        if (out_flit !== mk_flit(1'b1, 2'd1, 32'h3, 32'h0, 32'h0)) begin
            n_err++; $display("FAIL wrap_flit got %h want %h", out_flit, mk_flit(1'b1, 2'd1, 32'h3, 32'h0, 32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_flush();
        test_back_to_back();
        test_toggle();
        test_reset_midflight();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
